// File: rtl/dispensador_billetes_if.sv
// Signal bundle between the ATM controller / dispensing mechanism and the bill
// dispenser sequencer. The sequencer uses the slave view.
interface dispensador_billetes_if;
   logic        entregar_dinero;
   logic [31:0] monto;
   logic        billete_ok;
   logic        atasco;
   logic        expulsar;
   logic [2:0]  denominacion;
   logic        ocupado;
   logic        dispensado_ok;
   logic        error_monto;
   logic        error_atasco;
   logic [7:0]  cuenta_billetes;

   modport master (
      output entregar_dinero, monto, billete_ok, atasco,
      input  expulsar, denominacion, ocupado, dispensado_ok,
             error_monto, error_atasco, cuenta_billetes
   );

   modport slave (
      input  entregar_dinero, monto, billete_ok, atasco,
      output expulsar, denominacion, ocupado, dispensado_ok,
             error_monto, error_atasco, cuenta_billetes
   );
endinterface

// File: rtl/dispensador_billetes.sv
// Cash-dispenser sequencer: splits a withdrawal greedily into bills, ejects them
// one at a time and reports completion, an invalid amount or a mechanism jam.
module dispensador_billetes #(
   parameter int unsigned MAX_MONTO = 32'd400000,
   parameter int unsigned TIMEOUT   = 32'd16
) (
   input logic                   clk,
   input logic                   rst,
   dispensador_billetes_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      VALIDAR     = 3'd1,
      SELECCIONAR = 3'd2,
      EXPULSAR    = 3'd3,
      ESPERAR_ACK = 3'd4,
      FIN         = 3'd5,
      ERROR       = 3'd6,
      BLOQUEADO   = 3'd7
   } estado_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

   estado_t     state_r;
   estado_t     state_s;
   logic [31:0] restante_r;
   logic [2:0]  denominacion_r;
   logic [7:0]  cuenta_r;
   logic [7:0]  timeout_r;
   logic [31:0] restante_next_s;
   logic        monto_invalido_s;

   function automatic logic [31:0] valor_billete(input logic [2:0] code);
      logic [31:0] valor;
      case (code)
         3'd4:    valor = 32'd20000;
         3'd3:    valor = 32'd10000;
         3'd2:    valor = 32'd5000;
         3'd1:    valor = 32'd2000;
         default: valor = 32'd1000;
      endcase
      return valor;
   endfunction

   // Largest bill not exceeding the amount; validation guarantees at least 1000.
   function automatic logic [2:0] mayor_billete(input logic [31:0] importe);
      logic [2:0] code;
      if (importe >= 32'd20000)      code = 3'd4;
      else if (importe >= 32'd10000) code = 3'd3;
      else if (importe >= 32'd5000)  code = 3'd2;
      else if (importe >= 32'd2000)  code = 3'd1;
      else                           code = 3'd0;
      return code;
   endfunction

   assign restante_next_s  = restante_r - valor_billete(denominacion_r);
   assign monto_invalido_s = (restante_r == 32'd0)
                          || ((restante_r % 32'd1000) != 32'd0)
                          || (restante_r > MAX_MONTO);

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state_r <= IDLE;
      else      state_r <= state_s;
   end

   // Next-state logic; the ESPERAR_ACK branches follow jam > ack > timeout priority.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.entregar_dinero) state_s = VALIDAR;
            else                     state_s = IDLE;
         end
         VALIDAR: begin
            if (monto_invalido_s) state_s = ERROR;
            else                  state_s = SELECCIONAR;
         end
         SELECCIONAR: state_s = EXPULSAR;
         EXPULSAR:    state_s = ESPERAR_ACK;
         ESPERAR_ACK: begin
            if (bus.atasco)                      state_s = BLOQUEADO;
            else if (bus.billete_ok) begin
               if (restante_next_s == 32'd0)     state_s = FIN;
               else                              state_s = SELECCIONAR;
            end
            else if (timeout_r == TIMEOUT_LAST)  state_s = BLOQUEADO;
            else                                 state_s = ESPERAR_ACK;
         end
         FIN:       state_s = IDLE;
         ERROR:     state_s = IDLE;
         BLOQUEADO: state_s = BLOQUEADO;
         default:   state_s = IDLE;
      endcase
   end

   // Amount, bill selection, delivered-bill count and ack timeout registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         restante_r     <= 32'd0;
         denominacion_r <= 3'd0;
         cuenta_r       <= 8'd0;
         timeout_r      <= 8'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.entregar_dinero) begin
                  restante_r <= bus.monto;
                  cuenta_r   <= 8'd0;
               end
            end
            SELECCIONAR: begin
               denominacion_r <= mayor_billete(restante_r);
               timeout_r      <= 8'd0;
            end
            ESPERAR_ACK: begin
               if (!bus.atasco && bus.billete_ok) begin
                  restante_r <= restante_next_s;
                  cuenta_r   <= cuenta_r + 8'd1;
               end else if (!bus.atasco && (timeout_r != TIMEOUT_LAST)) begin
                  timeout_r <= timeout_r + 8'd1;
               end
            end
            default: begin
               restante_r <= restante_r;
            end
         endcase
      end
   end

   // Moore output decode from the registered state.
   always_comb begin
      bus.expulsar        = 1'b0;
      bus.dispensado_ok   = 1'b0;
      bus.error_monto     = 1'b0;
      bus.error_atasco    = 1'b0;
      bus.ocupado         = 1'b1;
      bus.denominacion    = denominacion_r;
      bus.cuenta_billetes = cuenta_r;
      case (state_r)
         IDLE:      bus.ocupado = 1'b0;
         EXPULSAR:  bus.expulsar = 1'b1;
         FIN:       bus.dispensado_ok = 1'b1;
         ERROR:     bus.error_monto = 1'b1;
         BLOQUEADO: begin
            bus.error_atasco = 1'b1;
            bus.ocupado      = 1'b0;
         end
         default:   bus.ocupado = 1'b1;
      endcase
   end
endmodule

// File: doc/dispensador_billetes.md
Name: dispensador_billetes

Overview:
- Cash-dispenser sequencer. It sits downstream of the ATM controller and is triggered by the controller's `entregar_dinero` output together with the withdrawal `monto`.
- It breaks `monto` into bills using a greedy algorithm over denominations 20000/10000/5000/2000/1000.
- It issues one eject request per bill to the dispensing mechanism and waits for each bill's acknowledge.
- It reports completion, an invalid amount, or a mechanism jam/timeout back to the controller.

Parameters:
- MAX_MONTO, 400000, largest amount accepted per withdrawal.
- TIMEOUT, 16, cycles to wait for `billete_ok` after each eject before declaring a jam (range 1..255).

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  reset: one clock; reset is synchronous and active-low.
- entregar_dinero  input  1  start pulse from the ATM controller.
- monto  input  32  withdrawal amount; sampled on the start edge.
- billete_ok  input  1  mechanism acknowledge: one bill delivered.
- atasco  input  1  mechanism jam indication.
- expulsar  output  1  one-cycle eject request.
- denominacion  output  3  cassette select: 4=20000, 3=10000, 2=5000, 1=2000, 0=1000.
- ocupado  output  1  high whenever not in IDLE or BLOQUEADO.
- dispensado_ok  output  1  one-cycle pulse when the full amount has been delivered.
- error_monto  output  1  one-cycle pulse when the amount is rejected.
- error_atasco  output  1  sticky jam/timeout flag.
- cuenta_billetes  output  8  bills delivered in the current or last withdrawal.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0.
  - Internal `restante` and the timeout counter are 0.
  - Reset overrides everything, including mid-withdrawal and BLOQUEADO.
- States: IDLE, VALIDAR, SELECCIONAR, EXPULSAR, ESPERAR_ACK, FIN, ERROR, BLOQUEADO.
- Outputs are Moore, decoded from registered state and registers.
- IDLE:
  - If `entregar_dinero`=1, latch `monto` into `restante`, clear `cuenta_billetes`, go to VALIDAR.
  - `entregar_dinero` is ignored in every other state.
- VALIDAR:
  - Go to ERROR if `restante`==0, or `restante` mod 1000 != 0, or `restante` > MAX_MONTO.
  - Otherwise go to SELECCIONAR.
- SELECCIONAR:
  - Register `denominacion` as the largest bill value <= `restante`.
  - Clear the timeout counter and go to EXPULSAR.
- EXPULSAR:
  - `expulsar`=1 for exactly this one cycle; `denominacion` is stable.
  - Unconditionally go to ESPERAR_ACK.
  - `billete_ok` is not sampled in this state.
- ESPERAR_ACK, evaluated in priority order each cycle:
  1. `atasco`=1 -> go to BLOQUEADO. `atasco` wins over a simultaneous `billete_ok`.
  2. `billete_ok`=1 -> `restante` -= bill value, `cuenta_billetes`++. Go to FIN if the new `restante`==0, else go to SELECCIONAR.
  3. Timeout counter == TIMEOUT-1 -> go to BLOQUEADO.
  4. Otherwise increment the timeout counter and stay.
- FIN: `dispensado_ok`=1 for one cycle, then go to IDLE.
- ERROR: `error_monto`=1 for one cycle, then go to IDLE. No eject has been issued.
- BLOQUEADO:
  - `error_atasco`=1 and held; `ocupado`=0.
  - Stays here until reset; `entregar_dinero` is ignored.
- `cuenta_billetes` holds its value after FIN or BLOQUEADO until the next accepted start.
- Latency:
  - `entregar_dinero` sampled at edge E -> VALIDAR after E -> SELECCIONAR after E+1 -> EXPULSAR after E+2.
  - So the first `expulsar` is high in the cycle following edge E+2.
  - Each subsequent bill takes at least 3 cycles: ESPERAR_ACK, SELECCIONAR, EXPULSAR.
- Arithmetic:
  - `restante` is 32-bit unsigned; subtraction never underflows because of the greedy selection.
  - The mod-1000 check may be implemented combinationally or iteratively, provided VALIDAR remains a single cycle.
- `billete_ok` held high for several cycles counts once per ESPERAR_ACK entry. Extra highs during SELECCIONAR or EXPULSAR are ignored.

Test Plan:
- Reset low, then release, then `monto`=38000 with a start pulse, acking each eject 2 cycles later:
  - Ejects with `denominacion` 4,3,2,1,0 in that order.
  - `dispensado_ok` pulses once; `cuenta_billetes`=5.
  - First `expulsar` appears 3 edges after the start edge.
- `monto`=40000 with immediate acks:
  - Two ejects, both `denominacion`=4; `cuenta_billetes`=2; then `dispensado_ok`.
  - A second start while `ocupado` is ignored.
- `monto`=1500, `monto`=0, and `monto`=MAX_MONTO+1000, each in turn:
  - Each gives an `error_monto` pulse 2 cycles after the start edge.
  - No `expulsar`; back in IDLE afterwards.
- `monto`=5000 with no `billete_ok`:
  - After 16 cycles in ESPERAR_ACK, `error_atasco`=1 and `ocupado`=0.
  - Further starts are ignored until rst=0.
- `monto`=3000, with the first ack asserted together with `atasco`:
  - BLOQUEADO, `cuenta_billetes`=0, `error_atasco`=1.
- `monto`=20000 with rst=0 asserted during ESPERAR_ACK:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A fresh start of 1000 then completes with `cuenta_billetes`=1.
